// File: rtl/fxp_div_pkg.sv
// Shared constants and state encoding for the sequential Q6.4 fixed-point divider.
package fxp_div_pkg;

  localparam int WIDTH = 10;
  localparam int FRAC  = 4;
  localparam int ITER  = WIDTH + FRAC;
  localparam int CNT_W = $clog2(ITER + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CALC,
    DONE
  } state_e;

endpackage

// File: rtl/fxp_div_datapath.sv
// Restoring shift-subtract datapath: operand, remainder and raw quotient registers.
module fxp_div_datapath
  import fxp_div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_b_zero,
  output logic [ITER-1:0]  o_quot
);

  logic [ITER-1:0]  r_dvd;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_rem;
  logic [ITER-1:0]  r_quot;

  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;
  logic             w_unused_diff_msb;

  // The shifted remainder needs one extra bit; a kept difference is below B and fits WIDTH bits.
  assign w_rem_sh          = {r_rem, r_dvd[ITER-1]};
  assign w_diff            = w_rem_sh - {1'b0, r_b};
  assign w_ge              = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_next        = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_unused_diff_msb = w_diff[WIDTH];

  assign o_b_zero = (i_b == '0);
  assign o_quot   = r_quot;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd  <= '0;
      r_b    <= '0;
      r_rem  <= '0;
      r_quot <= '0;
    end else if (i_clr) begin
      r_dvd  <= '0;
      r_b    <= '0;
      r_rem  <= '0;
      r_quot <= '0;
    end else if (i_load) begin
      r_dvd  <= {i_a, {FRAC{1'b0}}};
      r_b    <= i_b;
      r_rem  <= '0;
      r_quot <= '0;
    end else if (i_shift) begin
      r_dvd  <= {r_dvd[ITER-2:0], 1'b0};
      r_rem  <= w_rem_next;
      r_quot <= {r_quot[ITER-2:0], w_ge};
    end
  end

endmodule

// File: rtl/fxp_divider.sv
// Sequential unsigned Q6.4 divider: controller FSM, iteration counter and status flags.
// Define FXP_DIV_SATURATE_EN to force q to all ones whenever ovf is set.
module fxp_divider
  import fxp_div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclr,
  input  logic             start,
  input  logic [WIDTH-1:0] data_A,
  input  logic [WIDTH-1:0] data_B,
  output logic             valid,
  output logic             ovf,
  output logic             dvz,
  output logic             busy,
  output logic [WIDTH-1:0] q
);

  state_e           r_state;
  state_e           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;
  logic             r_dvz;
  logic             w_load;
  logic             w_shift;
  logic             w_accept;
  logic             w_last;
  logic             w_b_zero;
  logic [ITER-1:0]  w_quot;
  logic             w_ovf;

  fxp_div_datapath u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (sclr),
    .i_load   (w_load),
    .i_shift  (w_shift),
    .i_a      (data_A),
    .i_b      (data_B),
    .o_b_zero (w_b_zero),
    .o_quot   (w_quot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_state <= IDLE;
    else if (sclr) r_state <= IDLE;
    else           r_state <= w_state_next;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_state_next = LOAD;
      LOAD:       w_state_next = w_b_zero ? DONE : CALC;
      CALC:       if (w_last) w_state_next = DONE;
      default:    w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_load   = (r_state == LOAD);
    w_shift  = (r_state == CALC);
    w_accept = ((r_state == IDLE) || (r_state == DONE)) && start;
    busy     = w_load || w_shift;
  end

  assign w_last = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_dvz   <= 1'b0;
    end else if (sclr) begin
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_dvz   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_valid <= 1'b0;
        r_dvz   <= 1'b0;
      end
      if (w_load) begin
        r_cnt <= '0;
        if (w_b_zero) begin
          r_valid <= 1'b1;
          r_dvz   <= 1'b1;
        end
      end
      if (w_shift) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_last) r_valid <= 1'b1;
      end
    end
  end

  // The raw quotient is cleared on load, so a divide-by-zero result reads as zero without overflow.
  assign w_ovf = r_valid && (|w_quot[ITER-1:WIDTH]);
  assign valid = r_valid;
  assign dvz   = r_dvz;
  assign ovf   = w_ovf;

`ifdef FXP_DIV_SATURATE_EN
  assign q = !r_valid ? '0 : (w_ovf ? '1 : w_quot[WIDTH-1:0]);
`else
  assign q = r_valid ? w_quot[WIDTH-1:0] : '0;
`endif

endmodule

// File: tb/tb_fxp_divider.sv
// Directed and reference-model checks for fxp_divider: latency, flags, back-to-back runs, aborts.
module tb_fxp_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclr = 1'b0;
  logic       start = 1'b0;
  logic [9:0] data_A = '0;
  logic [9:0] data_B = '0;
  logic       valid;
  logic       ovf;
  logic       dvz;
  logic       busy;
  logic [9:0] q;

  int n_tests = 0;
  int n_fail  = 0;

  fxp_divider dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sclr   (sclr),
    .start  (start),
    .data_A (data_A),
    .data_B (data_B),
    .valid  (valid),
    .ovf    (ovf),
    .dvz    (dvz),
    .busy   (busy),
    .q      (q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, {31'd0, valid}, 32'd0);
    check({tag, ".ovf"},   {31'd0, ovf},   32'd0);
    check({tag, ".dvz"},   {31'd0, dvz},   32'd0);
    check({tag, ".busy"},  {31'd0, busy},  32'd0);
    check({tag, ".q"},     {22'd0, q},     32'd0);
  endtask

  // One full operation; cyc counts edges from the one that samples start.
  task automatic do_op(input string tag, input logic [9:0] a, input logic [9:0] b,
                       input logic [9:0] exp_q, input logic exp_ovf, input logic exp_dvz,
                       input int exp_lat);
    int cyc;
    @(negedge clk);
    start  = 1'b1;
    data_A = a;
    data_B = b;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    check({tag, ".busy_run"}, {31'd0, busy}, 32'd1);
    while (!valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".latency"}, cyc, exp_lat);
    check({tag, ".valid"}, {31'd0, valid}, 32'd1);
    check({tag, ".q"},     {22'd0, q},     {22'd0, exp_q});
    check({tag, ".ovf"},   {31'd0, ovf},   {31'd0, exp_ovf});
    check({tag, ".dvz"},   {31'd0, dvz},   {31'd0, exp_dvz});
    check({tag, ".busy_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic model_op(input string tag, input logic [9:0] a, input logic [9:0] b);
    int         raw;
    logic [9:0] eq;
    logic       eovf;
    if (b == '0) begin
      do_op(tag, a, b, 10'h000, 1'b0, 1'b1, 2);
    end else begin
      raw  = (int'(a) * 16) / int'(b);
      eovf = (raw > 1023);
      eq   = 10'(raw);
`ifdef FXP_DIV_SATURATE_EN
      if (eovf) eq = 10'h3FF;
`endif
      do_op(tag, a, b, eq, eovf, 1'b0, 16);
    end
  endtask

  initial begin
    logic [9:0] ra;
    logic [9:0] rb;
    logic [9:0] sat_q;

    repeat (2) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    do_op("int_9_3", 10'h090, 10'h030, 10'h030, 1'b0, 1'b0, 16);
    do_op("dvz",     10'h100, 10'h000, 10'h000, 1'b0, 1'b1, 2);

`ifdef FXP_DIV_SATURATE_EN
    sat_q = 10'h3FF;
`else
    sat_q = 10'h3F0;
`endif
    do_op("ovf", 10'h3FF, 10'h001, sat_q, 1'b1, 1'b0, 16);

    do_op("frac_a", 10'h008, 10'h048, 10'h001, 1'b0, 1'b0, 16);
    do_op("frac_b", 10'h191, 10'h103, 10'h018, 1'b0, 1'b0, 16);
    do_op("frac_c", 10'h048, 10'h018, 10'h030, 1'b0, 1'b0, 16);

    // sclr wins over a simultaneous start
    @(negedge clk);
    sclr   = 1'b1;
    start  = 1'b1;
    data_A = 10'h090;
    data_B = 10'h030;
    @(negedge clk);
    sclr  = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_idle("sclr_vs_start");

    // sclr mid-CALC
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("sclr_abort.busy_before", {31'd0, busy}, 32'd1);
    sclr = 1'b1;
    @(negedge clk);
    sclr = 1'b0;
    check_idle("sclr_abort");
    repeat (20) @(negedge clk);
    check_idle("sclr_abort_late");
    do_op("after_sclr", 10'h090, 10'h030, 10'h030, 1'b0, 1'b0, 16);

    // asynchronous reset mid-CALC, between clock edges
    @(negedge clk);
    start  = 1'b1;
    data_A = 10'h3FF;
    data_B = 10'h001;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle("async_abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (18) @(negedge clk);
    check_idle("async_abort_late");
    do_op("after_rst", 10'h090, 10'h030, 10'h030, 1'b0, 1'b0, 16);

    model_op("rnd_max", 10'h3FF, 10'h3FF);
    model_op("rnd_min", 10'h001, 10'h3FF);
    for (int i = 0; i < 16; i++) begin
      ra = 10'($urandom_range(0, 1023));
      rb = (i == 7) ? 10'h000 : 10'($urandom_range(0, 1023));
      model_op($sformatf("rnd%0d", i), ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
